// File: rtl/car_render_ctrl.sv
// Player-car render controller: erases the old 20x20 footprint, moves the origin on
// frame ticks, and forwards the sprite drawer's non-transparent pixels to the VGA port.
module car_render_ctrl (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] spr_x,
    input  logic [6:0] spr_y,
    input  logic [8:0] spr_colour,
    input  logic       spr_done,
    output logic [7:0] origin_x,
    output logic [6:0] origin_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [8:0] vga_colour,
    output logic       plot,
    output logic       busy
);

    localparam logic [8:0]        BG_COLOUR = 9'h000;
    localparam logic [8:0]        TRANS_KEY = 9'h1FF;
    localparam logic signed [9:0] STEP      = 10'sd2;
    localparam logic [7:0]        X_MAX     = 8'd140;
    localparam logic [6:0]        Y_MAX     = 7'd100;
    localparam logic [7:0]        X_INIT    = 8'd70;
    localparam logic [6:0]        Y_INIT    = 7'd50;
    localparam logic [4:0]        LAST      = 5'd19;

    typedef enum logic [2:0] {
        ARM   = 3'd0,
        DRAW  = 3'd1,
        IDLE  = 3'd2,
        ERASE = 3'd3,
        MOVE  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic              done_q_r;
    logic              done_rise_s;
    logic [4:0]        ex_r, ex_s, ey_r, ey_s;
    logic signed [9:0] dx_r, dx_s, dy_r, dy_s;
    logic signed [9:0] step_x_s, step_y_s;
    logic signed [9:0] sum_x_s, sum_y_s;
    logic [7:0]        org_x_r, org_x_s;
    logic [6:0]        org_y_r, org_y_s;
    logic [7:0]        vga_x_r, vga_x_s;
    logic [6:0]        vga_y_r, vga_y_s;
    logic [8:0]        vga_colour_r, vga_colour_s;
    logic              plot_r, plot_s;

    // Both or neither request in an axis cancel out.
    function automatic logic signed [9:0] dir_step(input logic neg, input logic pos);
        if (pos && !neg) begin
            dir_step = STEP;
        end else if (neg && !pos) begin
            dir_step = -STEP;
        end else begin
            dir_step = 10'sd0;
        end
    endfunction

    function automatic logic [7:0] clamp_x(input logic signed [9:0] v);
        if (v < 10'sd0) begin
            clamp_x = 8'd0;
        end else if (v > $signed({2'b00, X_MAX})) begin
            clamp_x = X_MAX;
        end else begin
            clamp_x = v[7:0];
        end
    endfunction

    function automatic logic [6:0] clamp_y(input logic signed [9:0] v);
        if (v < 10'sd0) begin
            clamp_y = 7'd0;
        end else if (v > $signed({3'b000, Y_MAX})) begin
            clamp_y = Y_MAX;
        end else begin
            clamp_y = v[6:0];
        end
    endfunction

    assign done_rise_s = spr_done & ~done_q_r;
    assign step_x_s    = dir_step(btn_left, btn_right);
    assign step_y_s    = dir_step(btn_up, btn_down);
    assign sum_x_s     = $signed({2'b00, org_x_r}) + dx_r;
    assign sum_y_s     = $signed({3'b000, org_y_r}) + dy_r;

    assign origin_x   = org_x_r;
    assign origin_y   = org_y_r;
    assign vga_x      = vga_x_r;
    assign vga_y      = vga_y_r;
    assign vga_colour = vga_colour_r;
    assign plot       = plot_r;
    assign busy       = (state_r != IDLE);

    // Next-state and next-output decode; vga_* hold their value when not plotting.
    always_comb begin
        state_s      = state_r;
        ex_s         = ex_r;
        ey_s         = ey_r;
        dx_s         = dx_r;
        dy_s         = dy_r;
        org_x_s      = org_x_r;
        org_y_s      = org_y_r;
        vga_x_s      = vga_x_r;
        vga_y_s      = vga_y_r;
        vga_colour_s = vga_colour_r;
        plot_s       = 1'b0;
        case (state_r)
            ARM: begin
                if (done_rise_s) begin
                    state_s = DRAW;
                end else begin
                    state_s = ARM;
                end
            end
            DRAW: begin
                if (done_rise_s) begin
                    state_s = IDLE;
                end else begin
                    vga_x_s      = spr_x;
                    vga_y_s      = spr_y;
                    vga_colour_s = spr_colour;
                    plot_s       = (spr_colour != TRANS_KEY);
                end
            end
            IDLE: begin
                if (frame_tick && ((step_x_s != 10'sd0) || (step_y_s != 10'sd0))) begin
                    dx_s    = step_x_s;
                    dy_s    = step_y_s;
                    ex_s    = 5'd0;
                    ey_s    = 5'd0;
                    state_s = ERASE;
                end else begin
                    state_s = IDLE;
                end
            end
            ERASE: begin
                vga_x_s      = org_x_r + {3'b000, ex_r};
                vga_y_s      = org_y_r + {2'b00, ey_r};
                vga_colour_s = BG_COLOUR;
                plot_s       = 1'b1;
                if (ex_r == LAST) begin
                    ex_s = 5'd0;
                    if (ey_r == LAST) begin
                        ey_s    = 5'd0;
                        state_s = MOVE;
                    end else begin
                        ey_s = ey_r + 5'd1;
                    end
                end else begin
                    ex_s = ex_r + 5'd1;
                end
            end
            MOVE: begin
                org_x_s = clamp_x(sum_x_s);
                org_y_s = clamp_y(sum_y_s);
                state_s = ARM;
            end
            default: begin
                state_s = ARM;
            end
        endcase
    end

    // State, scan, origin and VGA output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ARM;
            done_q_r     <= 1'b0;
            ex_r         <= 5'd0;
            ey_r         <= 5'd0;
            dx_r         <= 10'sd0;
            dy_r         <= 10'sd0;
            org_x_r      <= X_INIT;
            org_y_r      <= Y_INIT;
            vga_x_r      <= 8'd0;
            vga_y_r      <= 7'd0;
            vga_colour_r <= 9'd0;
            plot_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            done_q_r     <= spr_done;
            ex_r         <= ex_s;
            ey_r         <= ey_s;
            dx_r         <= dx_s;
            dy_r         <= dy_s;
            org_x_r      <= org_x_s;
            org_y_r      <= org_y_s;
            vga_x_r      <= vga_x_s;
            vga_y_r      <= vga_y_s;
            vga_colour_r <= vga_colour_s;
            plot_r       <= plot_s;
        end
    end

endmodule

// File: tb/tb_car_render_ctrl.sv
// Scoreboard bench for car_render_ctrl: a drawer model supplies sprite passes on
// request, stimulus pushes expected VGA writes, and a monitor pops them on every plot.
module tb_car_render_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [7:0] spr_x;
    logic [6:0] spr_y;
    logic [8:0] spr_colour;
    logic       spr_done;
    logic [7:0] origin_x;
    logic [6:0] origin_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [8:0] vga_colour;
    logic       plot;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int dp = 400;
    int pass_req = 0;
    int pass_used = 0;
    int mx = 70;
    int my = 50;
    logic [23:0] sb[$];

    always #5 clk = ~clk;

    car_render_ctrl dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour), .spr_done(spr_done),
        .origin_x(origin_x), .origin_y(origin_y),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .busy(busy)
    );

    // Sprite contains 37 transparent pixels (indices 100..136).
    function automatic logic [8:0] sprite_colour(input int p);
        if (p >= 100 && p < 137) return 9'h1FF;
        else return 9'(p);
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        else if (v > hi) return hi;
        else return v;
    endfunction

    assign spr_done   = (dp == 400);
    assign spr_x      = (dp < 400) ? origin_x + 8'(dp % 20) : 8'd0;
    assign spr_y      = (dp < 400) ? origin_y + 7'(dp / 20) : 7'd0;
    assign spr_colour = (dp < 400) ? sprite_colour(dp) : 9'd0;

    // Drawer: 400 pixels then parks with done high until another pass is requested.
    always @(posedge clk) begin
        if (dp < 400) begin
            dp <= dp + 1;
        end else if (pass_used < pass_req) begin
            dp <= 0;
            pass_used <= pass_used + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_erase(input int ox, input int oy);
        for (int ey = 0; ey < 20; ey++)
            for (int ex = 0; ex < 20; ex++)
                sb.push_back({8'(ox + ex), 7'(oy + ey), 9'h000});
    endtask

    task automatic push_draw(input int ox, input int oy);
        for (int p = 0; p < 400; p++) begin
            logic [8:0] c;
            c = sprite_colour(p);
            if (c != 9'h1FF) sb.push_back({8'(ox + p % 20), 7'(oy + p / 20), c});
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_queue_left"}, sb.size(), 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_origin_x"}, origin_x, mx);
        check({name, "_origin_y"}, origin_y, my);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_plot", plot, 0);
        check("rst_vga_x", vga_x, 0);
        check("rst_vga_y", vga_y, 0);
        check("rst_vga_colour", vga_colour, 0);
        check("rst_busy", busy, 1);
        check("rst_origin_x", origin_x, 70);
        check("rst_origin_y", origin_y, 50);
        sb.delete();
        mx = 70;
        my = 50;
        push_draw(mx, my);
        pass_req++;
        resetn = 1'b1;
        wait_done("reset_draw");
    endtask

    task automatic do_move(input logic l, input logic r, input logic u, input logic d,
                           input bit mid_tick, input string name);
        int dx, dy, nx, ny;
        dx = (r && !l) ? 2 : ((l && !r) ? -2 : 0);
        dy = (d && !u) ? 2 : ((u && !d) ? -2 : 0);
        nx = clampi(mx + dx, 140);
        ny = clampi(my + dy, 100);
        @(posedge clk); #1;
        btn_left = l; btn_right = r; btn_up = u; btn_down = d;
        frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        if (dx != 0 || dy != 0) begin
            push_erase(mx, my);
            push_draw(nx, ny);
            pass_req += 2;
            check({name, "_tick_plot"}, plot, 0);
            check({name, "_tick_busy"}, busy, 1);
            @(posedge clk); #1;
            check({name, "_first_erase_plot"}, plot, 1);
            for (int i = 2; i <= 400; i++) begin
                @(posedge clk); #1;
                frame_tick = (mid_tick && i == 50);
            end
            check({name, "_hold_origin_x"}, origin_x, mx);
            check({name, "_hold_origin_y"}, origin_y, my);
            @(posedge clk); #1;
            check({name, "_move_origin_x"}, origin_x, nx);
            check({name, "_move_origin_y"}, origin_y, ny);
            check({name, "_move_plot"}, plot, 0);
            mx = nx;
            my = ny;
            wait_done(name);
        end else begin
            check({name, "_no_erase_busy"}, busy, 0);
            repeat (20) @(posedge clk);
            #1;
            check({name, "_still_idle"}, busy, 0);
            check({name, "_origin_x"}, origin_x, mx);
            check({name, "_origin_y"}, origin_y, my);
        end
        btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    endtask

    task automatic reset_mid_erase();
        @(posedge clk); #1;
        btn_down = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        push_erase(mx, my);
        pass_req += 2;
        repeat (150) @(posedge clk);
        #1 resetn = 1'b0;
        btn_down = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_plot", plot, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_origin_x", origin_x, 70);
        check("mid_rst_origin_y", origin_y, 50);
        sb.delete();
        mx = 70;
        my = 50;
        push_draw(mx, my);
        resetn = 1'b1;
        wait_done("mid_rst_redraw");
    endtask

    // Monitor: every plot cycle must match the next expected VGA write.
    initial begin
        forever begin
            @(negedge clk);
            if (plot === 1'b1) begin
                check("plot_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    logic [23:0] e;
                    e = sb.pop_front();
                    check("pixel", {8'h00, vga_x, vga_y, vga_colour}, {8'h00, e});
                end
            end
        end
    end

    initial begin
        do_reset();
        do_move(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "right");
        do_move(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "lr_up_midtick");
        do_move(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "all_four");
        reset_mid_erase();
        for (int i = 0; i < 36; i++) do_move(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "down_right");
        check("max_origin_x", origin_x, 140);
        check("max_origin_y", origin_y, 100);
        do_reset();
        for (int i = 0; i < 36; i++) do_move(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "up_left");
        check("min_origin_x", origin_x, 0);
        check("min_origin_y", origin_y, 0);
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/car_render_ctrl.md
# car_render_ctrl

Frame-paced render controller for the player car. It owns the car's screen position, erases the old 20x20 footprint with the background colour, and moves the car on frame ticks. It supplies the sprite origin to the upstream 20x20 sprite drawer and forwards that drawer's pixel stream to the VGA adapter write port, dropping transparent pixels. It is the only VGA writer for the car layer.

## Interface
- BG_COLOUR, 9'h000: colour written during erase.
- TRANS_KEY, 9'h1FF: sprite colour that is never plotted.
- STEP, 2: pixels moved per frame tick per axis.
- X_MAX, 140: largest legal origin_x (160 - 20).
- Y_MAX, 100: largest legal origin_y (120 - 20).
- X_INIT, 70 and Y_INIT, 50: origin after reset.
- clk  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- frame_tick  in  1  one-cycle pulse per video frame.
- btn_left, btn_right, btn_up, btn_down  in  1 each  level direction requests.
- spr_x  in  8  sprite drawer pixel x (origin already added).
- spr_y  in  7  sprite drawer pixel y.
- spr_colour  in  9  sprite drawer pixel colour.
- spr_done  in  1  sprite drawer end-of-pass flag; its rising edge marks completion of pixel (19,19).
- origin_x  out  8  sprite origin to drawer.
- origin_y  out  7  sprite origin to drawer.
- vga_x  out  8, vga_y  out  7, vga_colour  out  9  VGA write data, registered.
- plot  out  1  VGA write enable, registered.
- busy  out  1  high in every state except IDLE.

## Operation
- States: ARM, DRAW, IDLE, ERASE, MOVE. Reset state ARM.
- ARM: wait for a spr_done rising edge (spr_done=1, previous sample 0); then go to DRAW. No plotting.
- DRAW: each cycle register spr_x/spr_y/spr_colour into vga_*; plot=1 unless spr_colour==TRANS_KEY. Leave to IDLE on the next spr_done rising edge; that cycle does not plot. Exactly 400 pixels are offered per DRAW.
- IDLE: on frame_tick, evaluate buttons. dx = +STEP if right only, -STEP if left only, 0 otherwise (both pressed or none). dy likewise (down = +). If dx==0 and dy==0, stay in IDLE. Otherwise latch dx/dy and go to ERASE.
- ERASE: internal 5-bit ex/ey scan from (0,0) to (19,19), x fastest. vga_x=origin_x+ex, vga_y=origin_y+ey, vga_colour=BG_COLOUR, plot=1 every cycle. After (19,19) go to MOVE.
- MOVE (1 cycle): origin_x = clamp(origin_x+dx, 0, X_MAX), origin_y = clamp(origin_y+dy, 0, Y_MAX). Compute with signed 10-bit intermediates; negative results go to 0, results above max go to max. Then go to ARM.
- frame_tick outside IDLE is dropped, not queued.
- Edge detector register for spr_done updates in every state, so an edge during DRAW-entry cycle is never missed.

## Timing
- Reset values: origin=(X_INIT,Y_INIT), plot=0, vga_x=0, vga_y=0, vga_colour=0, busy=1 (ARM), ex=ey=0, spr_done history=0.
- Reset asserted mid-ERASE or mid-DRAW: next cycle plot=0 and state=ARM; the partial footprint is left on screen and overdrawn by the post-reset draw.
- vga_* and plot lag their source (spr_* or ex/ey) by exactly 1 cycle.
- ERASE: 400 consecutive plot=1 cycles, starting the cycle after ERASE entry.
- frame_tick to first erase plot: 2 cycles. Erase end to origin update: 1 cycle.
- origin_* change only on the MOVE cycle; they are stable throughout ARM and DRAW.
- Full move cost: 1 + 400 + 1 + ARM wait (≤ 400) + 400 cycles, well under one frame.

## Test plan
- Reset, drawer model completes passes -> ARM waits one spr_done edge, then 400 offered pixels at origin (70,50) with plot asserted for every non-1FF pixel; busy falls after the second edge.
- IDLE, btn_right held, frame_tick -> 400 plots of 9'h000 covering x 70..89, y 50..69, then origin_x=72, redraw at 72.
- origin_x=1, btn_left, frame_tick -> origin_x=0; then origin_x=140, btn_right -> stays 140. Same for y at 0 and 100.
- btn_left and btn_right both held with btn_up -> dx=0, origin_y decreases by 2; all four held -> no ERASE, busy stays 0.
- Sprite with 37 pixels of colour 9'h1FF -> exactly 363 plot cycles in DRAW.
- frame_tick pulsed mid-ERASE -> ignored; reset at erase pixel 150 -> plot=0 next cycle, origin back to (70,50), state ARM.
